hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Pipeline sequencing block for the 5-stage MIPS datapath. It sits beside the datapath controller and drives stage write enables, bubbles and flushes.
- Detects load-use hazards, squashes wrong-path fetches on jumps and taken branches, and holds the pipeline while a multi-cycle multiply (SPECIAL2, opcode 011100) occupies EX.
- Provides the IFID_JFlush input consumed by the datapath controller.

Parameters:
- MUL_CYCLES, 4, total cycles a multiply occupies EX; legal range 1..2^CNT_W.
- CNT_W, 3, width of the multiply wait counter.
- STALL_CNT_W, 16, width of the stall performance counter (optional feature only).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IFID_Rs  in  5  rs field of the instruction in ID.
- IFID_Rt  in  5  rt field of the instruction in ID.
- IFID_UsesRt  in  1  ID instruction reads rt (R-type, branches, stores).
- IFID_Jump  in  1  Jump output of the datapath controller for the ID instruction.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_Rt  in  5  destination rt of the instruction in EX.
- IDEX_Mul  in  1  instruction in EX is a multiply.
- EX_BranchTaken  in  1  branch resolved taken in EX this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register write enable.
- IDEXWrite  out  1  ID/EX register write enable.
- IFID_JFlush  out  1  clear IF/ID at the next edge (jump or branch).
- IDEX_Bubble  out  1  load NOP controls into ID/EX at the next edge.
- EXMEM_Bubble  out  1  load NOP controls into EX/MEM at the next edge.
- MulBusy  out  1  multiply wait in progress.

Behaviour:
- Reset low, asynchronous:
  - State is RUN and Cnt is 0.
  - All outputs are 0, including PCWrite, IFIDWrite and IDEXWrite.
- Outputs are combinational from state, Cnt and inputs (Mealy); state and Cnt are registered.
- Default outputs (no rule active): PCWrite=IFIDWrite=IDEXWrite=1, all others 0.
- State RUN, rules in priority order (first match wins):
  1. MUL_CYCLES>1 and IDEX_Mul=1:
     - Outputs: PCWrite=IFIDWrite=IDEXWrite=0, EXMEM_Bubble=1, MulBusy=1.
     - Cnt<=MUL_CYCLES-2; next state MUL_WAIT.
     - EX_BranchTaken is ignored, since EX holds a multiply.
  2. EX_BranchTaken=1: IFID_JFlush=1, IDEX_Bubble=1, write enables stay 1.
  3. Load-use hazard, i.e. IDEX_MemRead=1, IDEX_Rt!=0, and (IDEX_Rt==IFID_Rs or (IFID_UsesRt and IDEX_Rt==IFID_Rt)):
     - Outputs: PCWrite=IFIDWrite=0, IDEX_Bubble=1.
     - Exactly one stall cycle; the bubble clears the hazard next cycle.
  4. IFID_Jump=1: IFID_JFlush=1.
- State MUL_WAIT:
  - Cnt!=0:
    - Outputs as in RUN rule 1; Cnt<=Cnt-1.
    - All other inputs are masked, including IFID_Jump and the hazard compare.
  - Cnt==0 (release cycle):
    - MulBusy=0, write enables 1, EXMEM_Bubble=0; next state RUN.
    - Rules 3 and 4 are evaluated this cycle. Rule 3 cannot fire because the EX instruction is a multiply; rule 4 can.
  - A multiply following directly behind re-enters MUL_WAIT on the next cycle through rule 1.
  - Total EX occupancy per multiply is exactly MUL_CYCLES cycles.
- MUL_CYCLES=1: rule 1 never fires and MUL_WAIT is unreachable.
- Register 0 never creates a load-use hazard.
- Reset asserted mid-MUL_WAIT: immediate return to RUN, Cnt=0. The pipeline owner flushes the stages.
- Simultaneous load-use and jump in the same cycle: the stall wins and IFID_JFlush=0. The jump is re-evaluated next cycle.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined:
  - Adds output StallCount [STALL_CNT_W-1:0].
  - StallCount increments on every cycle with PCWrite=0 and Reset high.
  - It saturates at all-ones and is cleared by Reset.
- When undefined: the port and counter are absent and all other behaviour is identical.

Test Plan:
- lw $5 in EX (IDEX_MemRead=1, IDEX_Rt=5), IFID_Rs=5 -> one cycle of PCWrite=0, IFIDWrite=0, IDEX_Bubble=1; next cycle (IDEX_MemRead=0) defaults restored.
- IDEX_MemRead=1, IDEX_Rt=0, IFID_Rs=0 -> no stall. IDEX_Rt=7, IFID_Rt=7, IFID_UsesRt=0 -> no stall.
- MUL_CYCLES=4, IDEX_Mul=1 at cycle 0 -> PCWrite=0 and MulBusy=1 in cycles 0-2; release in cycle 3 with MulBusy=0 and PCWrite=1. Repeat back-to-back -> a second 3-cycle stall immediately follows.
- IFID_Jump=1 during MUL_WAIT with Cnt!=0 -> IFID_JFlush=0; in the release cycle -> IFID_JFlush=1.
- EX_BranchTaken=1 together with a load-use hazard -> IFID_JFlush=1, IDEX_Bubble=1, PCWrite=1.
- Reset driven low at cycle 1 of MUL_WAIT -> all outputs 0 immediately; after release, PCWrite=1 with state RUN. With HAZ_PERF_CNT_EN defined, StallCount=0 after reset and counts 3 after one 4-cycle multiply.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline sequencing for the 5-stage MIPS datapath.
// It detects load-use hazards, squashes wrong-path fetches on jumps and taken
// branches, and holds the pipeline while a multi-cycle multiply occupies EX.
// Optional stall performance counter: define HAZ_PERF_CNT_EN to add StallCount.
// Outputs are Mealy (combinational from state, counter and inputs) and are
// forced low while Reset is asserted.
module hazard_stall_controller #(
`ifdef HAZ_PERF_CNT_EN
  parameter int unsigned STALL_CNT_W = 16,
`endif
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             IFID_Jump,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic             IDEX_Mul,
  input  logic             EX_BranchTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             IFID_JFlush,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Bubble,
  output logic             MulBusy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] StallCount
`endif
);

  // A single-cycle multiply never needs to hold the pipeline.
  localparam bit MUL_EN = (MUL_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = MUL_EN ? CNT_W'(MUL_CYCLES - 2) : '0;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic pc_write_c, ifid_write_c, idex_write_c;
  logic jflush_c, idex_bubble_c, exmem_bubble_c, mul_busy_c;
  logic load_use_c;

  // Load-use compare; register 0 is hardwired and never a hazard.
  always_comb begin
    load_use_c = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                 ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
  end

  // State and multiply wait counter.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and Mealy output decode with rule priority.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    pc_write_c     = 1'b1;
    ifid_write_c   = 1'b1;
    idex_write_c   = 1'b1;
    jflush_c       = 1'b0;
    idex_bubble_c  = 1'b0;
    exmem_bubble_c = 1'b0;
    mul_busy_c     = 1'b0;
    case (state)
      RUN: begin
        if (MUL_EN && IDEX_Mul) begin
          pc_write_c     = 1'b0;
          ifid_write_c   = 1'b0;
          idex_write_c   = 1'b0;
          exmem_bubble_c = 1'b1;
          mul_busy_c     = 1'b1;
          cnt_nxt        = CNT_LOAD;
          state_nxt      = MUL_WAIT;
        end else if (EX_BranchTaken) begin
          jflush_c      = 1'b1;
          idex_bubble_c = 1'b1;
        end else if (load_use_c) begin
          pc_write_c    = 1'b0;
          ifid_write_c  = 1'b0;
          idex_bubble_c = 1'b1;
        end else if (IFID_Jump) begin
          jflush_c = 1'b1;
        end
      end
      MUL_WAIT: begin
        if (cnt != '0) begin
          pc_write_c     = 1'b0;
          ifid_write_c   = 1'b0;
          idex_write_c   = 1'b0;
          exmem_bubble_c = 1'b1;
          mul_busy_c     = 1'b1;
          cnt_nxt        = cnt - CNT_W'(1);
        end else begin
          // Release cycle: only the hazard and jump rules apply.
          state_nxt = RUN;
          if (load_use_c) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
          end else if (IFID_Jump) begin
            jflush_c = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Hold every output low during reset.
  always_comb begin
    PCWrite      = Reset & pc_write_c;
    IFIDWrite    = Reset & ifid_write_c;
    IDEXWrite    = Reset & idex_write_c;
    IFID_JFlush  = Reset & jflush_c;
    IDEX_Bubble  = Reset & idex_bubble_c;
    EXMEM_Bubble = Reset & exmem_bubble_c;
    MulBusy      = Reset & mul_busy_c;
  end

`ifdef HAZ_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt;

  // Saturating count of cycles with the PC held.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stall_cnt <= '0;
    end else if (!pc_write_c && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign StallCount = stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: table vectors, hand sequences for the
// multiply/reset corners, then random stimulus against a behavioural model.
module tb_hazard_stall_controller;

  localparam int MULC = 4;

  // Output vector order: {pc, ifid, idex, jflush, idex_bub, exmem_bub, busy}
  localparam logic [6:0] DEF = 7'b1110000;
  localparam logic [6:0] LU  = 7'b0010100;
  localparam logic [6:0] BR  = 7'b1111100;
  localparam logic [6:0] JMP = 7'b1111000;
  localparam logic [6:0] MUL = 7'b0000011;
  localparam logic [6:0] RST = 7'b0000000;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       jump;
    logic       memread;
    logic [4:0] idex_rt;
    logic       mul;
    logic       br;
    logic [6:0] exp;
  } vec_t;

  logic       Clock, Reset;
  logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
  logic       IFID_UsesRt, IFID_Jump, IDEX_MemRead, IDEX_Mul, EX_BranchTaken;
  logic       PCWrite, IFIDWrite, IDEXWrite, IFID_JFlush, IDEX_Bubble, EXMEM_Bubble, MulBusy;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] StallCount;
`endif

  int total = 0;
  int bad   = 0;
  int m_occ = 0;           // cycles the current multiply has already spent in EX
  int unsigned m_cnt = 0;  // expected stall counter

  hazard_stall_controller #(.MUL_CYCLES(MULC), .CNT_W(3)) dut (
    .Clock(Clock), .Reset(Reset),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IFID_Jump(IFID_Jump), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .IDEX_Mul(IDEX_Mul), .EX_BranchTaken(EX_BranchTaken),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .IFID_JFlush(IFID_JFlush), .IDEX_Bubble(IDEX_Bubble),
    .EXMEM_Bubble(EXMEM_Bubble), .MulBusy(MulBusy)
`ifdef HAZ_PERF_CNT_EN
    , .StallCount(StallCount)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic vec_t mkv(input int rs, input int rt, input bit uses, input bit jump,
                               input bit memread, input int idex_rt, input bit mul,
                               input bit br, input logic [6:0] exp);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = uses; v.jump = jump;
    v.memread = memread; v.idex_rt = 5'(idex_rt); v.mul = mul; v.br = br; v.exp = exp;
    return v;
  endfunction

  // Reference: rule priority evaluated from the multiply's age in EX.
  function automatic void model(input vec_t v, input int occ, output logic [6:0] o,
                                output int occ_n);
    bit lu;
    lu = v.memread && (v.idex_rt != 0) &&
         ((v.idex_rt == v.rs) || (v.uses_rt && (v.idex_rt == v.rt)));
    o = DEF;
    occ_n = 0;
    if (occ > 0 && occ < MULC - 1) begin
      o = MUL; occ_n = occ + 1;
    end else if (occ > 0 && occ == MULC - 1) begin
      if (lu) o = LU; else if (v.jump) o = JMP;
    end else if (MULC > 1 && v.mul) begin
      o = MUL; occ_n = 1;
    end else if (v.br) o = BR;
    else if (lu) o = LU;
    else if (v.jump) o = JMP;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // One clock cycle: drive after the edge, compare at the falling edge.
  task automatic do_cycle(input vec_t v, input logic rst, input bit use_tab, input string name);
    logic [6:0] mo, want;
    int nocc;
    @(posedge Clock);
    #1;
    Reset = rst;
    IFID_Rs = v.rs; IFID_Rt = v.rt; IFID_UsesRt = v.uses_rt; IFID_Jump = v.jump;
    IDEX_MemRead = v.memread; IDEX_Rt = v.idex_rt; IDEX_Mul = v.mul; EX_BranchTaken = v.br;
    @(negedge Clock);
    model(v, m_occ, mo, nocc);
    want = !rst ? RST : (use_tab ? v.exp : mo);
    check(name, 16'({PCWrite, IFIDWrite, IDEXWrite, IFID_JFlush, IDEX_Bubble,
                     EXMEM_Bubble, MulBusy}), 16'(want));
`ifdef HAZ_PERF_CNT_EN
    check({name, "_cnt"}, StallCount, 16'(m_cnt));
`endif
    if (!rst) begin
      m_occ = 0; m_cnt = 0;
    end else begin
      m_occ = nocc;
      if (!mo[6] && m_cnt < 32'd65535) m_cnt++;
    end
  endtask

  vec_t tab[22];
  vec_t nop;

  initial begin
    Reset = 1'b0;
    IFID_Rs = '0; IFID_Rt = '0; IFID_UsesRt = 1'b0; IFID_Jump = 1'b0;
    IDEX_MemRead = 1'b0; IDEX_Rt = '0; IDEX_Mul = 1'b0; EX_BranchTaken = 1'b0;
    nop = mkv(0, 0, 0, 0, 0, 0, 0, 0, DEF);

    //             rs rt us jp mr xrt mul br exp
    tab[0]  = mkv(5, 0, 0, 0, 1, 5, 0, 0, LU);   // lw $5 -> use of $5
    tab[1]  = mkv(5, 0, 0, 0, 0, 5, 0, 0, DEF);  // bubble cleared the hazard
    tab[2]  = mkv(0, 0, 0, 0, 1, 0, 0, 0, DEF);  // $0 never stalls
    tab[3]  = mkv(3, 7, 0, 0, 1, 7, 0, 0, DEF);  // rt not read
    tab[4]  = mkv(3, 7, 1, 0, 1, 7, 0, 0, LU);   // rt read
    tab[5]  = mkv(5, 0, 0, 0, 1, 5, 0, 1, BR);   // branch beats load-use
    tab[6]  = mkv(1, 2, 0, 1, 0, 0, 0, 0, JMP);
    tab[7]  = mkv(4, 0, 0, 1, 1, 4, 0, 0, LU);   // stall wins over jump
    tab[8]  = mkv(4, 0, 0, 1, 0, 4, 0, 0, JMP);  // jump re-evaluated
    tab[9]  = mkv(0, 0, 0, 0, 0, 0, 1, 0, MUL);  // multiply cycle 0
    tab[10] = mkv(0, 0, 0, 1, 0, 0, 1, 0, MUL);  // jump masked
    tab[11] = mkv(0, 0, 0, 1, 0, 0, 1, 1, MUL);  // jump and branch masked
    tab[12] = mkv(0, 0, 0, 1, 0, 0, 1, 0, JMP);  // release cycle, jump honoured
    tab[13] = mkv(0, 0, 0, 0, 0, 0, 1, 0, MUL);  // back-to-back multiply
    tab[14] = mkv(0, 0, 0, 0, 0, 0, 1, 0, MUL);
    tab[15] = mkv(0, 0, 0, 0, 0, 0, 1, 0, MUL);
    tab[16] = mkv(0, 0, 0, 0, 0, 0, 0, 0, DEF);  // release
    tab[17] = mkv(0, 0, 0, 0, 0, 0, 1, 1, MUL);  // branch ignored under mul
    tab[18] = mkv(0, 0, 0, 0, 0, 0, 1, 0, MUL);
    tab[19] = mkv(0, 0, 0, 0, 0, 0, 1, 0, MUL);
    tab[20] = mkv(0, 0, 0, 0, 0, 0, 0, 0, DEF);
    tab[21] = mkv(2, 2, 1, 0, 0, 2, 0, 0, DEF);

    // Reset state.
    do_cycle(nop, 1'b0, 1'b1, "reset0");
    do_cycle(nop, 1'b0, 1'b1, "reset1");

    for (int i = 0; i < 22; i++) begin
      do_cycle(tab[i], 1'b1, 1'b1, $sformatf("tab%0d", i));
    end

    // Reset in the first MUL_WAIT cycle, then resume in RUN.
    do_cycle(mkv(0, 0, 0, 0, 0, 0, 1, 0, MUL), 1'b1, 1'b1, "rmul0");
    do_cycle(mkv(0, 0, 0, 0, 0, 0, 1, 0, RST), 1'b0, 1'b1, "rmul_rst");
    do_cycle(nop, 1'b1, 1'b1, "rmul_run");
`ifdef HAZ_PERF_CNT_EN
    check("cnt_after_reset", StallCount, 16'd0);
`endif
    do_cycle(mkv(0, 0, 0, 0, 0, 0, 1, 0, MUL), 1'b1, 1'b1, "pm0");
    do_cycle(mkv(0, 0, 0, 0, 0, 0, 1, 0, MUL), 1'b1, 1'b1, "pm1");
    do_cycle(mkv(0, 0, 0, 0, 0, 0, 1, 0, MUL), 1'b1, 1'b1, "pm2");
    do_cycle(nop, 1'b1, 1'b1, "pm_rel");
    do_cycle(nop, 1'b1, 1'b1, "pm_after");
`ifdef HAZ_PERF_CNT_EN
    check("cnt_one_mul", StallCount, 16'd3);
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      vec_t v;
      logic r;
      v.rs      = 5'($urandom_range(0, 3));
      v.rt      = 5'($urandom_range(0, 3));
      v.uses_rt = 1'($urandom_range(0, 1));
      v.jump    = ($urandom_range(0, 3) == 0);
      v.memread = ($urandom_range(0, 1) == 0);
      v.idex_rt = 5'($urandom_range(0, 3));
      v.mul     = ($urandom_range(0, 5) == 0);
      v.br      = ($urandom_range(0, 5) == 0);
      v.exp     = DEF;
      r         = ($urandom_range(0, 79) != 0);
      do_cycle(v, r, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
